serial_alu_ctrl: RTL and testbench
==================================

// Module: serial_alu_ctrl
// PURPOSE
//  Bit-serial sequencer for the 1-bit logic/shift slice of the midterm ALU.
//  - Runs a WIDTH-bit operation through the single combinational slice, one bit per clock, LSB first.
//  - Chains the slice carry between cycles and assembles the WIDTH-bit result.
//  - Sits between the register file/top level and the slice instance; talks to requesters by start/busy/done.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range is WIDTH >= 2.
// PORTS
//  clk           in   1      single clock; all state changes on the rising edge.
//  rst           in   1      asynchronous, active-high reset.
//  start         in   1      request; sampled only in IDLE or DONE.
//  abort         in   1      cancel an operation in progress; sampled only in RUN.
//  a             in   WIDTH  operand A; latched on an accepted start.
//  b             in   WIDTH  operand B; latched on an accepted start.
//  opsel         in   3      000 AND, 001 OR, 010 XOR, 011 NOT a, 1xx shift a left by 1.
//  sin           in   1      shift-in bit (new LSB) for 1xx; latched on start.
//  busy          out  1      high while in RUN.
//  done          out  1      one-cycle pulse; result and cout are valid from this cycle onward.
//  result        out  WIDTH  last completed result; held until the next completion.
//  cout          out  1      last completed carry-out: a[WIDTH-1] for 1xx, 0 for logic ops.
//  slice_op1     out  1      to slice op1 = a_sh[0].
//  slice_op2     out  1      to slice op2 = b_sh[0].
//  slice_opsel   out  3      to slice opsel = latched opsel in RUN, 3'b000 otherwise.
//  slice_cin     out  1      to slice Cin_final = carry register.
//  slice_result  in   1      from slice logic_result; combinational, same cycle.
//  slice_cout    in   1      from slice logic_Cout; combinational, same cycle.
// BEHAVIOUR
//  - Reset: state=IDLE; a_sh, b_sh, acc, carry, cnt, result, cout all 0; busy=0, done=0.
//    All slice_* outputs are 0. Reset takes effect immediately, including mid-RUN.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE --start & !abort--> RUN.
//    On entry: a_sh<=a, b_sh<=b, op_q<=opsel, carry<=sin, cnt<=0.
//    Start asserted together with abort is ignored.
//  - Each RUN cycle:
//    acc <= {slice_result, acc[WIDTH-1:1]};
//    carry <= slice_cout;
//    a_sh and b_sh shift right by one;
//    cnt <= cnt + 1.
//  - RUN --cnt==WIDTH-1--> DONE.
//    In that same edge: result <= {slice_result, acc[WIDTH-1:1]}; cout <= slice_cout.
//  - RUN --abort--> IDLE. No done pulse; result and cout keep their prior values.
//    Abort takes priority over completion on the last bit.
//  - DONE: done=1 for exactly one cycle.
//    start in DONE is accepted (back-to-back; same entry actions), otherwise go to IDLE.
//  - start while in RUN is ignored; there is no queueing.
//  - Latency: start accepted at edge 0 -> done high during the cycle after edge WIDTH.
//    Throughput is one operation per WIDTH+1 cycles.
//  - Shift op: the slice outputs carry-in as result and op1 as carry-out.
//    Chaining therefore gives result = {a[WIDTH-2:0], sin} and cout = a[WIDTH-1].
//  - cnt width is $clog2(WIDTH). cnt never wraps because the FSM leaves RUN at WIDTH-1.
//  - b is don't-care for NOT and shift, but is still latched.
// STRUCTURE
//  - alu_pkg:
//    typedef enum logic [2:0] opsel_e {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL=3'b100};
//    typedef enum logic [1:0] sctl_state_e {S_IDLE, S_RUN, S_DONE}.
//  - Single module; no sub-module. The slice is instantiated beside it at top level, wired via slice_*.
// TESTING (WIDTH=8, slice connected, done counted from the accepting edge)
//  - AND a=0xCA b=0x0F -> result=0x0A, cout=0, busy for 8 cycles, done at cycle 9.
//  - OR 0xA0|0x05 -> 0xA5; XOR 0xFF^0x55 -> 0xAA; NOT a=0x3C -> 0xC3.
//  - SHL a=0x81 sin=1 -> result=0x03, cout=1. SHL a=0x40 sin=0 -> 0x80, cout=0.
//  - start pulsed mid-RUN -> ignored, and the original result completes.
//    start in the DONE cycle -> second op begins with no IDLE gap.
//  - abort at RUN cycle 4 after a 0x0A completion -> IDLE next cycle, no done, result stays 0x0A.
//  - rst asserted mid-RUN between edges -> busy, result, cout and slice_* go to 0 with no clock;
//    after release, a new op completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: opcode encoding and controller states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOT = 3'b011,
        OP_SHL = 3'b100
    } opsel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } sctl_state_e;

endpackage

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer: feeds one operand bit per clock (LSB first) through the external
// 1-bit logic/shift slice, chains its carry and assembles the WIDTH-bit result.
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opsel,
    input  logic             sin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             slice_op1,
    output logic             slice_op2,
    output logic [2:0]       slice_opsel,
    output logic             slice_cin,
    input  logic             slice_result,
    input  logic             slice_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    sctl_state_e      state;
    sctl_state_e      next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic             in_run;
    logic             accept;
    logic             last_bit;

    assign in_run   = (state == S_RUN);
    // Start is only honoured between operations; start together with abort is dropped.
    assign accept   = start && !abort && ((state == S_IDLE) || (state == S_DONE));
    assign last_bit = (cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort wins over completion on the last bit.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) next_state = S_RUN;
                else        next_state = S_IDLE;
            end
            S_RUN: begin
                if (abort)         next_state = S_IDLE;
                else if (last_bit) next_state = S_DONE;
                else               next_state = S_RUN;
            end
            S_DONE: begin
                if (accept) next_state = S_RUN;
                else        next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operand shifters, accumulator, carry chain and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            op_q  <= 3'b000;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= opsel;
            carry <= sin;
            cnt   <= '0;
        end else if (in_run) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            acc   <= {slice_result, acc[WIDTH-1:1]};
            carry <= slice_cout;
            cnt   <= cnt + CW'(1);
        end else begin
            a_sh  <= a_sh;
        end
    end

    // Published result and carry-out, updated only on an un-aborted last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            cout   <= 1'b0;
        end else if (in_run && last_bit && !abort) begin
            result <= {slice_result, acc[WIDTH-1:1]};
            cout   <= slice_cout;
        end else begin
            result <= result;
        end
    end

    assign busy        = in_run;
    assign done        = (state == S_DONE);
    assign slice_op1   = a_sh[0];
    assign slice_op2   = b_sh[0];
    assign slice_opsel = in_run ? op_q : 3'b000;
    assign slice_cin   = carry;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: behavioural slice beside the DUT, directed
// boundary cases plus randomized operations checked against a word-level reference.
module tb_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opsel;
    logic         sin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         slice_op1;
    logic         slice_op2;
    logic [2:0]   slice_opsel;
    logic         slice_cin;
    logic         slice_result;
    logic         slice_cout;

    int checks = 0;
    int errors = 0;
    logic [W:0] expv;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a(a), .b(b), .opsel(opsel), .sin(sin),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .slice_op1(slice_op1), .slice_op2(slice_op2),
        .slice_opsel(slice_opsel), .slice_cin(slice_cin),
        .slice_result(slice_result), .slice_cout(slice_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-bit slice: logic ops give carry 0; shift passes carry-in out and op1 on as carry.
    always_comb begin
        slice_result = 1'b0;
        slice_cout   = 1'b0;
        if (slice_opsel[2]) begin
            slice_result = slice_cin;
            slice_cout   = slice_op1;
        end else begin
            case (slice_opsel[1:0])
                2'b00:   slice_result = slice_op1 & slice_op2;
                2'b01:   slice_result = slice_op1 | slice_op2;
                2'b10:   slice_result = slice_op1 ^ slice_op2;
                default: slice_result = ~slice_op1;
            endcase
        end
    end

    function automatic logic [W:0] ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] op, input logic s);
        if (op[2]) return {x, s};
        case (op[1:0])
            2'b00:   return {1'b0, x & y};
            2'b01:   return {1'b0, x | y};
            2'b10:   return {1'b0, x ^ y};
            default: return {1'b0, ~x};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present an operation and let the next rising edge accept it.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [2:0] iop, input logic isin);
        a = ia; b = ib; opsel = iop; sin = isin; start = 1'b1; abort = 1'b0;
        expv = ref_alu(ia, ib, iop, isin);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_on_accept", busy, 1);
    endtask

    // Wait (bounded) for done, optionally pulsing a spurious start after edge inject.
    task automatic wait_done(input int inject);
        int n = 0;
        int busy_cycles = 1;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_cycles++;
            if (inject != 0 && n == inject) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom); opsel = 3'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq("latency", n, W);
        check_eq("busy_cycles", busy_cycles, W);
        check_eq("result", result, expv[W-1:0]);
        check_eq("cout", cout, expv[W]);
    endtask

    task automatic idle_after();
        @(posedge clk); #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        a = '0; b = '0; opsel = 3'b000; sin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_cout", cout, 0);
        check_eq("rst_slice", {slice_op1, slice_op2, slice_opsel, slice_cin}, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        issue(8'hCA, 8'h0F, 3'b000, 1'b0); wait_done(0); idle_after();
        issue(8'hA0, 8'h05, 3'b001, 1'b0); wait_done(0); idle_after();
        issue(8'hFF, 8'h55, 3'b010, 1'b0); wait_done(0); idle_after();
        issue(8'h3C, 8'h99, 3'b011, 1'b0); wait_done(0); idle_after();
        issue(8'h81, 8'h00, 3'b100, 1'b1); wait_done(0); idle_after();
        issue(8'h40, 8'hFF, 3'b111, 1'b0); wait_done(0); idle_after();

        // Spurious start mid-RUN must not disturb the running operation.
        issue(8'h5A, 8'h33, 3'b010, 1'b0); wait_done(3); idle_after();

        // Back-to-back: start presented during the DONE cycle.
        issue(8'h12, 8'h34, 3'b001, 1'b0); wait_done(0);
        issue(8'hF0, 8'h3C, 3'b000, 1'b0); wait_done(0); idle_after();

        // Start together with abort in IDLE is ignored.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_ignored", busy, 0);

        // Abort in RUN cycle 4 after a 0x0A completion.
        issue(8'h0A, 8'hFF, 3'b000, 1'b0); wait_done(0); idle_after();
        issue(8'h55, 8'hFF, 3'b001, 1'b0);
        repeat (3) @(posedge clk);
        #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_result", result, 8'h0A);
        check_eq("abort_cout", cout, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("abort_no_done", done, 0);
        end

        // Abort on the last bit beats completion.
        issue(8'h81, 8'h00, 3'b100, 1'b1);
        repeat (7) @(posedge clk);
        #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check_eq("abort_last_done", done, 0);
        check_eq("abort_last_busy", busy, 0);
        check_eq("abort_last_result", result, 8'h0A);
        check_eq("abort_last_cout", cout, 0);

        // Asynchronous reset mid-RUN, between clock edges.
        issue(8'hC3, 8'h00, 3'b100, 1'b1);
        repeat (3) @(posedge clk);
        #2; rst = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_result", result, 0);
        check_eq("arst_cout", cout, 0);
        check_eq("arst_slice", {slice_op1, slice_op2, slice_opsel, slice_cin}, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        issue(8'hB7, 8'h6D, 3'b010, 1'b0); wait_done(0); idle_after();

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));
            wait_done(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 2)) : 0);
            if ($urandom_range(0, 2) != 0) idle_after();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
